// File: rtl/neureka_job_dispatch_pkg.sv
// rtl/neureka_job_dispatch_pkg.sv - shared constants and job/slot types for the NEUREKA job dispatcher
package neureka_job_dispatch_pkg;

    localparam int NEUREKA_N_ENGINES = 2;
    localparam int NEUREKA_N_CONTEXT = 2;
    localparam int NEUREKA_N_CORES   = 8;
    localparam int NEUREKA_ID_W      = 8;
    localparam int NEUREKA_JOB_W     = 32;
    localparam int NEUREKA_CORE_W    = $clog2(NEUREKA_N_CORES);

    // One queued or running job: who asked for it and where its register file lives.
    typedef struct packed {
        logic [NEUREKA_ID_W-1:0]   id;
        logic [NEUREKA_CORE_W-1:0] core;
        logic [NEUREKA_JOB_W-1:0]  desc;
    } neureka_job_t;

    // Per-engine ownership record; busy is the only engine state we track.
    typedef struct packed {
        logic         busy;
        neureka_job_t job;
    } neureka_slot_t;

endpackage

// File: rtl/neureka_job_dispatch_fifo.sv
// rtl/neureka_job_dispatch_fifo.sv - synchronous job queue with count, full and empty
module neureka_job_dispatch_fifo
    import neureka_job_dispatch_pkg::*;
#(
    parameter int DEPTH = NEUREKA_N_CONTEXT,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  neureka_job_t       data_i,
    output neureka_job_t       data_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [CNT_W-1:0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    neureka_job_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Storage is not reset; only pointers and count decide what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping; caller never pushes when full or pops when empty.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_i) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push_i && !pop_i) begin
                count <= count + 1'b1;
            end else if (pop_i && !push_i) begin
                count <= count - 1'b1;
            end
        end
    end

    assign data_o  = mem[rd_ptr];
    assign full_o  = (count == CNT_W'(DEPTH));
    assign empty_o = (count == '0);
    assign count_o = count;

endmodule

// File: rtl/neureka_job_dispatch.sv
// rtl/neureka_job_dispatch.sv - round-robin job dispatcher over N engines with per-core completion events
module neureka_job_dispatch
    import neureka_job_dispatch_pkg::*;
#(
    parameter  int N_ENGINES = NEUREKA_N_ENGINES,
    parameter  int N_CONTEXT = NEUREKA_N_CONTEXT,
    parameter  int N_CORES   = NEUREKA_N_CORES,
    parameter  int ID_W      = NEUREKA_ID_W,
    parameter  int JOB_W     = NEUREKA_JOB_W,
    localparam int CORE_W    = $clog2(N_CORES),
    localparam int CNT_W     = $clog2(N_CONTEXT + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      job_valid_i,
    output logic                      job_ready_o,
    input  logic [ID_W-1:0]           job_id_i,
    input  logic [CORE_W-1:0]         job_core_i,
    input  logic [JOB_W-1:0]          job_desc_i,
    output logic [N_ENGINES-1:0]      eng_start_o,
    output logic [N_ENGINES*JOB_W-1:0] eng_desc_o,
    input  logic [N_ENGINES-1:0]      eng_done_i,
    output logic [N_ENGINES-1:0]      done_valid_o,
    output logic [N_ENGINES*ID_W-1:0] done_id_o,
    output logic [N_CORES-1:0]        evt_o,
    output logic [N_ENGINES-1:0]      eng_busy_o,
    output logic [CNT_W-1:0]          queue_cnt_o,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int PTR_W = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;

    neureka_slot_t             slot [N_ENGINES];
    logic [PTR_W-1:0]          rr_ptr;
    logic [PTR_W-1:0]          cand;
    logic [PTR_W-1:0]          sel_idx;
    logic                      sel_found;
    neureka_job_t              in_job;
    neureka_job_t              head_job;
    neureka_job_t              disp_job;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      accept;
    logic                      disp_valid;
    logic                      push;
    logic                      pop;
    logic [N_ENGINES-1:0]      start_q;
    logic [N_ENGINES-1:0]      done_valid_q;
    logic [N_ENGINES*ID_W-1:0] done_id_q;
    logic [N_CORES-1:0]        evt_q;
    logic [N_CORES-1:0]        evt_next;
    logic                      err_q;

    assign job_ready_o = !fifo_full && !rst_i && !clear_i;
    assign accept      = job_valid_i && job_ready_o;

    assign in_job.id   = job_id_i;
    assign in_job.core = job_core_i;
    assign in_job.desc = job_desc_i;

    // An empty queue lets the incoming job go straight to an engine so it starts the next cycle.
    assign disp_job   = fifo_empty ? in_job : head_job;
    assign disp_valid = (!fifo_empty || accept) && sel_found;
    assign pop        = disp_valid && !fifo_empty;
    assign push       = accept && !(disp_valid && fifo_empty);

    neureka_job_dispatch_fifo #(
        .DEPTH (N_CONTEXT),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (in_job),
        .data_o  (head_job),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (queue_cnt_o)
    );

    // First idle engine at or after the round-robin pointer; an engine finishing this cycle is still busy.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_ENGINES; i++) begin
            cand = PTR_W'((int'(rr_ptr) + i) % N_ENGINES);
            if (!sel_found && !slot[cand].busy) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Completion events: OR of the owning cores of every busy engine reporting done.
    always_comb begin
        evt_next = '0;
        for (int k = 0; k < N_ENGINES; k++) begin
            if (eng_done_i[k] && slot[k].busy) begin
                evt_next[slot[k].job.core] = 1'b1;
            end
        end
    end

    // Engine ownership, pulses and sticky error; clear drops in-flight jobs without reporting them.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            for (int k = 0; k < N_ENGINES; k++) begin
                slot[k] <= '0;
            end
            rr_ptr       <= '0;
            start_q      <= '0;
            done_valid_q <= '0;
            done_id_q    <= '0;
            evt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            start_q      <= '0;
            done_valid_q <= '0;
            evt_q        <= evt_next;
            for (int k = 0; k < N_ENGINES; k++) begin
                if (eng_done_i[k]) begin
                    if (slot[k].busy) begin
                        slot[k].busy                  <= 1'b0;
                        done_valid_q[k]               <= 1'b1;
                        done_id_q[k*ID_W +: ID_W]     <= slot[k].job.id;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
            end
            if (disp_valid) begin
                slot[sel_idx].busy <= 1'b1;
                slot[sel_idx].job  <= disp_job;
                start_q[sel_idx]   <= 1'b1;
                rr_ptr             <= (sel_idx == PTR_W'(N_ENGINES - 1)) ? '0 : sel_idx + 1'b1;
            end
        end
    end

    // Flatten per-engine slot state onto the output buses.
    always_comb begin
        eng_desc_o = '0;
        eng_busy_o = '0;
        for (int k = 0; k < N_ENGINES; k++) begin
            eng_desc_o[k*JOB_W +: JOB_W] = slot[k].job.desc;
            eng_busy_o[k]                = slot[k].busy;
        end
    end

    assign eng_start_o  = start_q;
    assign done_valid_o = done_valid_q;
    assign done_id_o    = done_id_q;
    assign evt_o        = evt_q;
    assign err_o        = err_q;
    assign busy_o       = (queue_cnt_o != '0) || (|eng_busy_o);

endmodule

// File: tb/tb_neureka_job_dispatch.sv
// tb/tb_neureka_job_dispatch.sv - self-checking bench for neureka_job_dispatch
module tb_neureka_job_dispatch;

    localparam int NE     = 2;
    localparam int NC     = 2;
    localparam int NCORES = 8;
    localparam int IDW    = 8;
    localparam int JW     = 32;
    localparam int CW     = 3;
    localparam int QW     = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              job_valid;
    logic              job_ready;
    logic [IDW-1:0]    job_id;
    logic [CW-1:0]     job_core;
    logic [JW-1:0]     job_desc;
    logic [NE-1:0]     eng_start;
    logic [NE*JW-1:0]  eng_desc;
    logic [NE-1:0]     eng_done;
    logic [NE-1:0]     done_valid;
    logic [NE*IDW-1:0] done_id;
    logic [NCORES-1:0] evt;
    logic [NE-1:0]     eng_busy;
    logic [QW-1:0]     queue_cnt;
    logic              busy;
    logic              err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    neureka_job_dispatch #(
        .N_ENGINES (NE),
        .N_CONTEXT (NC),
        .N_CORES   (NCORES),
        .ID_W      (IDW),
        .JOB_W     (JW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (clear),
        .job_valid_i  (job_valid),
        .job_ready_o  (job_ready),
        .job_id_i     (job_id),
        .job_core_i   (job_core),
        .job_desc_i   (job_desc),
        .eng_start_o  (eng_start),
        .eng_desc_o   (eng_desc),
        .eng_done_i   (eng_done),
        .done_valid_o (done_valid),
        .done_id_o    (done_id),
        .evt_o        (evt),
        .eng_busy_o   (eng_busy),
        .queue_cnt_o  (queue_cnt),
        .busy_o       (busy),
        .err_o        (err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded job queue plus per-engine ownership.
    typedef struct packed {
        logic [IDW-1:0] id;
        logic [CW-1:0]  core;
        logic [JW-1:0]  desc;
    } mjob_t;

    mjob_t             q[$];
    mjob_t             m_job [NE];
    logic [NE-1:0]     m_busy;
    logic [NE-1:0]     m_start;
    logic [NE-1:0]     m_dv;
    logic [IDW-1:0]    m_did [NE];
    logic [NCORES-1:0] m_evt;
    int                m_rr;
    bit                m_err;
    bit                m_valid = 1'b0;
    logic [NE-1:0]     bb;
    bit                placed;
    mjob_t             nj;
    int                ek;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("ready", 64'(job_ready), 64'(!rst && !clear && (q.size() < NC)));
            chk("eng_start", 64'(eng_start), 64'(m_start));
            chk("eng_busy", 64'(eng_busy), 64'(m_busy));
            for (int k = 0; k < NE; k++) begin
                chk("eng_desc", 64'(eng_desc[k*JW +: JW]), 64'(m_job[k].desc));
                if (m_dv[k]) begin
                    chk("done_id", 64'(done_id[k*IDW +: IDW]), 64'(m_did[k]));
                end
            end
            chk("done_valid", 64'(done_valid), 64'(m_dv));
            chk("evt", 64'(evt), 64'(m_evt));
            chk("queue_cnt", 64'(queue_cnt), 64'(q.size()));
            chk("busy", 64'(busy), 64'((q.size() != 0) || (m_busy != '0)));
            chk("err", 64'(err), 64'(m_err));
        end
        bb      = m_busy;
        m_start = '0;
        m_dv    = '0;
        m_evt   = '0;
        if (rst || clear) begin
            q.delete();
            for (int k = 0; k < NE; k++) begin
                m_job[k] = '0;
                m_did[k] = '0;
            end
            m_busy  = '0;
            m_rr    = 0;
            m_err   = 1'b0;
            m_valid = 1'b1;
        end else begin
            for (int k = 0; k < NE; k++) begin
                if (eng_done[k]) begin
                    if (m_busy[k]) begin
                        m_busy[k] = 1'b0;
                        m_dv[k]   = 1'b1;
                        m_did[k]  = m_job[k].id;
                        m_evt[m_job[k].core] = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
            if (job_valid && q.size() < NC) begin
                nj.id   = job_id;
                nj.core = job_core;
                nj.desc = job_desc;
                q.push_back(nj);
            end
            placed = 1'b0;
            if (q.size() > 0) begin
                for (int i = 0; i < NE; i++) begin
                    ek = (m_rr + i) % NE;
                    if (!placed && !bb[ek]) begin
                        placed     = 1'b1;
                        m_job[ek]  = q.pop_front();
                        m_busy[ek] = 1'b1;
                        m_start[ek] = 1'b1;
                        m_rr       = (ek + 1) % NE;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_job(input logic [IDW-1:0] id, input logic [CW-1:0] core, input logic [JW-1:0] desc);
        job_valid = 1'b1;
        job_id    = id;
        job_core  = core;
        job_desc  = desc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        job_valid = 1'b1;
        job_id    = '0;
        job_core  = '0;
        job_desc  = '0;
        eng_done  = '0;

        // Reset held with a job offered.
        repeat (3) begin
            tick();
            chk("rst_ready", 64'(job_ready), 64'(0));
            chk("rst_outputs", 64'({eng_busy, eng_start, done_valid, evt, queue_cnt, busy, err}), 64'(0));
        end
        rst       = 1'b0;
        job_valid = 1'b0;
        #1;
        chk("post_rst_ready", 64'(job_ready), 64'(1));
        chk("post_rst_cnt", 64'(queue_cnt), 64'(0));

        // Single job, done ten cycles after acceptance.
        set_job(8'h11, 3'd3, 32'hA5A5_0011);
        tick();
        job_valid = 1'b0;
        chk("t2_start", 64'(eng_start), 64'(2'b01));
        chk("t2_desc", 64'(eng_desc[JW-1:0]), 64'(32'hA5A5_0011));
        repeat (9) tick();
        eng_done = 2'b01;
        tick();
        eng_done = 2'b00;
        chk("t2_done_valid", 64'(done_valid), 64'(2'b01));
        chk("t2_done_id", 64'(done_id[IDW-1:0]), 64'(8'h11));
        chk("t2_evt", 64'(evt), 64'(8'b0000_1000));
        chk("t2_busy", 64'(eng_busy), 64'(2'b00));

        // Round-robin and backpressure with five back-to-back jobs.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_job(8'(32'h20 + i), 3'((i == 0) ? 1 : ((i == 1) ? 6 : i)), 32'hC000_0000 + 32'(i));
            if (i == 4) begin
                #1;
                chk("t3_ready_full", 64'(job_ready), 64'(0));
                chk("t3_cnt_full", 64'(queue_cnt), 64'(2));
            end
            tick();
            if (i == 0) chk("t3_start0", 64'(eng_start), 64'(2'b01));
            if (i == 1) chk("t3_start1", 64'(eng_start), 64'(2'b10));
        end
        job_valid = 1'b0;
        chk("t3_cnt", 64'(queue_cnt), 64'(2));

        // Both engines finish together; queued jobs then go to engine 0, then 1.
        eng_done = 2'b11;
        tick();
        eng_done = 2'b00;
        chk("t4_done_valid", 64'(done_valid), 64'(2'b11));
        chk("t4_evt", 64'(evt), 64'(8'b0100_0010));
        chk("t4_done_id", 64'(done_id), 64'(16'h2120));
        tick();
        chk("t4_start0", 64'(eng_start), 64'(2'b01));
        chk("t4_desc0", 64'(eng_desc[JW-1:0]), 64'(32'hC000_0002));
        tick();
        chk("t4_start1", 64'(eng_start), 64'(2'b10));
        chk("t4_desc1", 64'(eng_desc[2*JW-1:JW]), 64'(32'hC000_0003));
        chk("t4_cnt", 64'(queue_cnt), 64'(0));

        // Clear while jobs are running and queued.
        do_reset();
        set_job(8'h31, 3'd2, 32'h0000_0031);
        tick();
        set_job(8'h32, 3'd4, 32'h0000_0032);
        tick();
        set_job(8'h33, 3'd5, 32'h0000_0033);
        tick();
        job_valid = 1'b0;
        chk("t5_cnt_before", 64'(queue_cnt), 64'(1));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t5_cnt", 64'(queue_cnt), 64'(0));
        chk("t5_eng_busy", 64'(eng_busy), 64'(0));
        chk("t5_busy", 64'(busy), 64'(0));
        eng_done = 2'b01;
        tick();
        eng_done = 2'b00;
        chk("t5_err", 64'(err), 64'(1));
        chk("t5_evt", 64'(evt), 64'(0));
        chk("t5_done_valid", 64'(done_valid), 64'(0));

        // Spurious done on an idle engine.
        do_reset();
        chk("t6_err_clear", 64'(err), 64'(0));
        eng_done = 2'b10;
        tick();
        eng_done = 2'b00;
        chk("t6_err", 64'(err), 64'(1));
        chk("t6_evt", 64'(evt), 64'(0));
        repeat (3) tick();
        chk("t6_err_sticky", 64'(err), 64'(1));

        // Randomised traffic checked by the model every cycle.
        do_reset();
        repeat (3000) begin
            job_valid = ($urandom_range(0, 9) < 6);
            job_id    = 8'($urandom);
            job_core  = 3'($urandom);
            job_desc  = $urandom;
            for (int k = 0; k < NE; k++) begin
                eng_done[k] = (m_busy[k] && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 199) == 0);
            end
            clear = ($urandom_range(0, 99) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            tick();
        end
        job_valid = 1'b0;
        eng_done  = '0;
        clear     = 1'b0;
        rst       = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
